// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: hazard/redirect controls, instruction-memory port and IF/ID outputs.
// The master side is the fetch stage; the slave side is the surrounding pipeline/memory.
interface fetch_stage_if;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] imem_pc_o;
   logic [31:0] imem_inst_i;
   logic [31:0] ifid_pc_o;
   logic [31:0] ifid_pc4_o;
   logic [31:0] ifid_inst_o;
   logic        ifid_valid_o;
   logic        halt_o;
   logic        misalign_o;
   logic [31:0] fetch_count_o;

   modport master (
      input  stall_i, redirect_i, redirect_pc_i, imem_inst_i,
      output imem_pc_o, ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o,
             halt_o, misalign_o, fetch_count_o
   );

   modport slave (
      output stall_i, redirect_i, redirect_pc_i, imem_inst_i,
      input  imem_pc_o, ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o,
             halt_o, misalign_o, fetch_count_o
   );
endinterface

// File: rtl/fetch_stage.sv
// RISC-V instruction-fetch stage: owns the PC, reads instruction memory and fills IF/ID.
// Halts when the PC leaves instruction memory; only a redirect or reset restarts it.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_DEPTH = 51,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);

   localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

   typedef enum logic {RUN, HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic [31:0] ifid_inst_q, ifid_inst_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic        misalign_q, misalign_d;
   logic [31:0] count_q, count_d;
   logic        in_range;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign in_range = ({2'b00, pc_q[31:2]} < DEPTH_W);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RUN;
         pc_q         <= RESET_PC;
         ifid_pc_q    <= '0;
         ifid_pc4_q   <= '0;
         ifid_inst_q  <= NOP_INST;
         ifid_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_inst_q  <= ifid_inst_d;
         ifid_valid_q <= ifid_valid_d;
         misalign_q   <= misalign_d;
         count_q      <= count_d;
      end
   end

   // Redirect beats stall; stall freezes everything including HALT.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_inst_d  = ifid_inst_q;
      ifid_valid_d = ifid_valid_q;
      misalign_d   = misalign_q;
      count_d      = count_q;
      if (bus.redirect_i) begin
         pc_d         = {bus.redirect_pc_i[31:2], 2'b00};
         ifid_pc_d    = '0;
         ifid_pc4_d   = '0;
         ifid_inst_d  = NOP_INST;
         ifid_valid_d = 1'b0;
         misalign_d   = misalign_q | (bus.redirect_pc_i[1:0] != 2'b00);
         state_d      = RUN;
      end else if (!bus.stall_i) begin
         ifid_pc_d    = '0;
         ifid_pc4_d   = '0;
         ifid_inst_d  = NOP_INST;
         ifid_valid_d = 1'b0;
         case (state_q)
            RUN: begin
               if (in_range) begin
                  ifid_pc_d    = pc_q;
                  ifid_pc4_d   = pc_q + 32'd4;
                  ifid_inst_d  = bus.imem_inst_i;
                  ifid_valid_d = 1'b1;
                  pc_d         = pc_q + 32'd4;
                  count_d      = sat_inc(count_q);
               end else begin
                  state_d = HALT;
               end
            end
            default: state_d = HALT;
         endcase
      end
   end

   assign bus.imem_pc_o     = pc_q;
   assign bus.ifid_pc_o     = ifid_pc_q;
   assign bus.ifid_pc4_o    = ifid_pc4_q;
   assign bus.ifid_inst_o   = ifid_inst_q;
   assign bus.ifid_valid_o  = ifid_valid_q;
   assign bus.halt_o        = (state_q == HALT);
   assign bus.misalign_o    = misalign_q;
   assign bus.fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a behavioural fetch model.
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int          DEPTH = 51;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_stage_if bus();

   fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   logic [31:0] mem [0:DEPTH-1];

   function automatic logic [31:0] imem_read(input logic [31:0] a);
      if ({2'b00, a[31:2]} < 32'(DEPTH)) return mem[a[7:2]];
      return 32'hDEADBEEF;
   endfunction

   assign bus.imem_inst_i = imem_read(bus.imem_pc_o);

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model of the architected fetch state.
   logic [31:0] m_pc, m_ipc, m_ipc4, m_inst, m_cnt;
   logic        m_valid, m_halt, m_mis;

   task automatic model_reset();
      m_pc = 32'h0; m_ipc = 0; m_ipc4 = 0; m_inst = NOP; m_valid = 0;
      m_halt = 0; m_mis = 0; m_cnt = 0;
   endtask

   task automatic model_bubble();
      m_ipc = 0; m_ipc4 = 0; m_inst = NOP; m_valid = 0;
   endtask

   task automatic model_step();
      if (bus.redirect_i) begin
         m_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
         model_bubble();
         if (bus.redirect_pc_i % 4 != 0) m_mis = 1;
         m_halt = 0;
      end else if (!bus.stall_i) begin
         if (!m_halt && (m_pc / 4) < DEPTH) begin
            m_ipc = m_pc; m_ipc4 = m_pc + 4; m_inst = mem[m_pc / 4]; m_valid = 1;
            m_pc = m_pc + 4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         end else begin
            model_bubble();
            m_halt = 1;
         end
      end
   endtask

   function automatic logic [162:0] obs();
      return {bus.imem_pc_o, bus.ifid_pc_o, bus.ifid_pc4_o, bus.ifid_inst_o,
              bus.fetch_count_o, bus.ifid_valid_o, bus.halt_o, bus.misalign_o};
   endfunction

   function automatic logic [162:0] expv();
      return {m_pc, m_ipc, m_ipc4, m_inst, m_cnt, m_valid, m_halt, m_mis};
   endfunction

   task automatic edge_step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic rd, input logic [31:0] tgt);
      bus.stall_i = st; bus.redirect_i = rd; bus.redirect_pc_i = tgt;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(0, 0, 0);
      @(posedge clk); #1;
      model_reset();
      n_cmp++;
      if (obs() !== expv()) begin
         n_bad++; $display("FAIL reset_state: got %h expected %h", obs(), expv());
      end
      n_cmp++;
      if (bus.ifid_inst_o !== NOP) begin
         n_bad++; $display("FAIL reset_nop: got %h expected %h", bus.ifid_inst_o, NOP);
      end
      rst = 1'b0;
   endtask

   task automatic test_free_run();
      logic [31:0] want [0:2];
      want[0] = 32'h00500093; want[1] = 32'h00A00113; want[2] = 32'h002081B3;
      for (int i = 0; i < 3; i++) begin
         edge_step();
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++; $display("FAIL free_run_%0d: got %h expected %h", i, obs(), expv());
         end
         n_cmp++;
         if ({bus.ifid_pc_o, bus.ifid_inst_o, bus.ifid_valid_o} !== {32'(i * 4), want[i], 1'b1}) begin
            n_bad++; $display("FAIL free_run_word_%0d: got pc %h inst %h v %b expected pc %h inst %h v 1",
                              i, bus.ifid_pc_o, bus.ifid_inst_o, bus.ifid_valid_o, i * 4, want[i]);
         end
      end
      n_cmp++;
      if (bus.fetch_count_o !== 32'd3) begin
         n_bad++; $display("FAIL free_run_count: got %0d expected 3", bus.fetch_count_o);
      end
   endtask

   task automatic test_stall();
      test_reset();
      edge_step(); edge_step();
      drive(1, 0, 0);
      for (int i = 0; i < 2; i++) begin
         edge_step();
         n_cmp++;
         if ({bus.imem_pc_o, bus.ifid_pc_o, bus.ifid_inst_o, bus.fetch_count_o} !==
             {32'h8, 32'h4, 32'h00A00113, 32'd2}) begin
            n_bad++; $display("FAIL stall_hold_%0d: got pc %h ifid %h/%h cnt %0d expected 8 4/00a00113 2",
                              i, bus.imem_pc_o, bus.ifid_pc_o, bus.ifid_inst_o, bus.fetch_count_o);
         end
      end
      drive(0, 0, 0);
      edge_step();
      n_cmp++;
      if (obs() !== expv() || bus.ifid_pc_o !== 32'h8) begin
         n_bad++; $display("FAIL stall_release: got %h expected %h", obs(), expv());
      end
   endtask

   task automatic test_redirect_stall();
      drive(1, 1, 32'h20);
      edge_step();
      n_cmp++;
      if ({bus.imem_pc_o, bus.ifid_inst_o, bus.ifid_valid_o} !== {32'h20, NOP, 1'b0}) begin
         n_bad++; $display("FAIL redirect_over_stall: got pc %h inst %h v %b expected 20 %h 0",
                           bus.imem_pc_o, bus.ifid_inst_o, bus.ifid_valid_o, NOP);
      end
      drive(0, 0, 0);
      edge_step();
      n_cmp++;
      if ({bus.ifid_pc_o, bus.ifid_valid_o} !== {32'h20, 1'b1} || obs() !== expv()) begin
         n_bad++; $display("FAIL redirect_follow: got %h expected %h", obs(), expv());
      end
   endtask

   task automatic test_misalign();
      drive(0, 1, 32'h16);
      edge_step();
      n_cmp++;
      if ({bus.imem_pc_o, bus.misalign_o} !== {32'h14, 1'b1}) begin
         n_bad++; $display("FAIL misalign_set: got pc %h mis %b expected 14 1", bus.imem_pc_o, bus.misalign_o);
      end
      drive(0, 1, 32'h20);
      edge_step();
      drive(0, 0, 0);
      edge_step(); edge_step();
      n_cmp++;
      if (bus.misalign_o !== 1'b1 || obs() !== expv()) begin
         n_bad++; $display("FAIL misalign_sticky: got %h expected %h", obs(), expv());
      end
   endtask

   task automatic test_halt();
      drive(0, 1, 32'hC0);
      edge_step();
      drive(0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         edge_step();
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++; $display("FAIL halt_run_%0d: got %h expected %h", i, obs(), expv());
         end
      end
      n_cmp++;
      if ({bus.halt_o, bus.imem_pc_o, bus.ifid_valid_o} !== {1'b1, 32'hCC, 1'b0}) begin
         n_bad++; $display("FAIL halt_state: got halt %b pc %h v %b expected 1 cc 0",
                           bus.halt_o, bus.imem_pc_o, bus.ifid_valid_o);
      end
      drive(0, 1, 32'h0);
      edge_step();
      drive(0, 0, 0);
      n_cmp++;
      if ({bus.halt_o, bus.imem_pc_o} !== {1'b0, 32'h0}) begin
         n_bad++; $display("FAIL halt_exit: got halt %b pc %h expected 0 0", bus.halt_o, bus.imem_pc_o);
      end
      edge_step();
      n_cmp++;
      if ({bus.ifid_pc_o, bus.ifid_valid_o} !== {32'h0, 1'b1}) begin
         n_bad++; $display("FAIL halt_restart: got pc %h v %b expected 0 1", bus.ifid_pc_o, bus.ifid_valid_o);
      end
   endtask

   task automatic test_async_reset();
      edge_step(); edge_step();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      n_cmp++;
      if (obs() !== expv()) begin
         n_bad++; $display("FAIL async_reset: got %h expected %h", obs(), expv());
      end
      @(posedge clk); #1;
      rst = 1'b0;
      edge_step();
      n_cmp++;
      if ({bus.ifid_pc_o, bus.ifid_valid_o, bus.fetch_count_o} !== {32'h0, 1'b1, 32'd1}) begin
         n_bad++; $display("FAIL async_reset_restart: got pc %h v %b cnt %0d expected 0 1 1",
                           bus.ifid_pc_o, bus.ifid_valid_o, bus.fetch_count_o);
      end
   endtask

   task automatic test_saturation();
      drive(0, 1, 32'h0);
      edge_step();
      drive(0, 0, 0);
      force dut.count_q = 32'hFFFF_FFFD;
      #1;
      release dut.count_q;
      m_cnt = 32'hFFFF_FFFD;
      for (int i = 0; i < 4; i++) edge_step();
      n_cmp++;
      if (bus.fetch_count_o !== 32'hFFFF_FFFF || obs() !== expv()) begin
         n_bad++; $display("FAIL saturation: got cnt %h expected ffffffff (full %h vs %h)",
                           bus.fetch_count_o, obs(), expv());
      end
   endtask

   task automatic test_random();
      logic [31:0] tgt;
      test_reset();
      for (int i = 0; i < 400; i++) begin
         tgt = 32'($urandom_range(0, 32'hE0));
         drive($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, tgt);
         edge_step();
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++; $display("FAIL random_%0d: got %h expected %h", i, obs(), expv());
         end
      end
      drive(0, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      mem[0] = 32'h00500093; mem[1] = 32'h00A00113; mem[2] = 32'h002081B3;
      mem[3] = 32'h00000013; mem[4] = 32'h00000013;
      rst = 1'b1;
      drive(0, 0, 0);
      #1;
      test_reset();
      test_free_run();
      test_stall();
      test_redirect_stall();
      test_misalign();
      test_halt();
      test_async_reset();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RISC-V pipeline.
- Owns the program counter and drives the instruction memory word address.
- Takes the combinational instruction word back from the instruction memory and registers PC, PC+4 and the instruction into the IF/ID pipeline register for decode.
- Handles decode stalls, EX-stage branch/jump redirects, misaligned targets, and running off the end of instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_DEPTH, 51, number of 32-bit words in the instruction memory. Any PC with (PC>>2) >= IMEM_DEPTH is out of range.
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  reset.
- stall_i  input  1  hazard unit: hold PC and IF/ID.
- redirect_i  input  1  EX: branch taken or jump.
- redirect_pc_i  input  32  EX: target address.
- imem_pc_o  output  32  byte address to instruction memory (= PC register).
- imem_inst_i  input  32  instruction word returned combinationally for imem_pc_o.
- ifid_pc_o  output  32  IF/ID: PC of the held instruction.
- ifid_pc4_o  output  32  IF/ID: that PC + 4.
- ifid_inst_o  output  32  IF/ID: instruction word.
- ifid_valid_o  output  1  IF/ID: 1 = real instruction, 0 = bubble.
- halt_o  output  1  fetch is in HALT state.
- misalign_o  output  1  sticky: a redirect target had [1:0] != 0.
- fetch_count_o  output  32  number of valid instructions delivered to IF/ID.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All state is clocked on the rising edge of clk.
- Reset values (asserted asynchronously, at any time including mid-operation):
  - PC = RESET_PC
  - ifid_pc_o = 0, ifid_pc4_o = 0, ifid_inst_o = NOP_INST, ifid_valid_o = 0
  - state = RUN, halt_o = 0, misalign_o = 0, fetch_count_o = 0
- Latency: the instruction at PC=N appears on the ifid_* outputs on the edge after imem_pc_o=N. imem_pc_o is always the PC register; there is no combinational path from any input to it.
- in_range = ((PC>>2) < IMEM_DEPTH).
- Per-edge priority: rst > redirect_i > stall_i > normal.
- Redirect (overrides stall_i):
  - PC <= {redirect_pc_i[31:2], 2'b00}.
  - IF/ID <= bubble: pc = 0, pc4 = 0, inst = NOP_INST, valid = 0.
  - If redirect_pc_i[1:0] != 0, misalign_o <= 1; it then stays 1 until reset.
  - state <= RUN.
- Stall without redirect: PC, IF/ID, state and counter all hold.
- Normal, state RUN, in_range:
  - IF/ID <= {PC, PC+4, imem_inst_i, valid = 1}.
  - PC <= PC+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Normal, state RUN, not in_range:
  - IF/ID <= bubble.
  - PC holds.
  - state <= HALT.
- State HALT (no redirect): PC holds; IF/ID loads a bubble every cycle; halt_o = 1. Only a redirect or reset leaves HALT.
- A redirect to an out-of-range target enters RUN, then re-enters HALT on the next normal edge.
- fetch_count_o:
  - Increments by 1 on every edge where IF/ID captures valid = 1.
  - Saturates at 0xFFFF_FFFF (no wrap).
  - Never increments on bubbles, stalls or redirects.
- PC+4 for ifid_pc4_o is a 32-bit sum, carry discarded.

Test Plan:
- Reset then free-run, memory words 0..4 = 0x00500093, 0x00A00113, 0x002081B3, 0x00000013, 0x00000013 -> imem_pc_o 0,4,8,...; ifid_pc_o/ifid_inst_o one cycle later 0/0x00500093, 4/0x00A00113, ...; ifid_valid_o = 1; fetch_count_o = 3 after three edges.
- stall_i high 2 cycles while PC=8 -> imem_pc_o stays 8; IF/ID holds pc 4 / 0x00A00113; count unchanged; resumes at 8 after release.
- redirect_i with target 0x20 while stall_i also high -> next PC = 0x20; IF/ID = bubble (NOP_INST, valid 0); following edge shows pc 0x20 valid 1.
- Redirect target 0x0000_0016 -> PC = 0x14; misalign_o = 1 and stays 1 across later redirects until rst.
- Run to PC = 0xCC (word 51, IMEM_DEPTH = 51) -> halt_o = 1; PC frozen at 0xCC; ifid_valid_o = 0 each cycle; redirect to 0x0 -> halt_o = 0, fetch restarts at 0.
- Assert rst asynchronously mid-stream (between edges) -> all outputs immediately at reset values; fetch restarts from RESET_PC after deassertion. Separately, preload fetch_count_o near saturation (force) -> saturates at 0xFFFF_FFFF.
